median_filter_par: RTL and testbench
====================================

MEDIAN_FILTER_PAR -- requirements
Module: median_filter_par

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits; legal range 2..16.
REQ-002 Parameter WIN, default 5, window length in samples; odd values 3..9 only; any other value shall stop elaboration with an error.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port clr_i  input  1  synchronous window flush.
REQ-006 Port mode_i  input  2  operation: 0 median, 1 min, 2 max, 3 bypass.
REQ-007 Port dat_i  input  DATA_W  input sample, unsigned.
REQ-008 Port val_i  input  1  dat_i is valid this cycle; no backpressure, every valid sample is accepted.
REQ-009 Port dat_o  output  DATA_W  filtered sample, registered.
REQ-010 Port val_o  output  1  dat_o is valid; single-cycle pulse per result, registered.

Function
REQ-011 Window: WIN x DATA_W shift register, w[0] newest; on an accepted sample (val_i=1), w[k] <= w[k-1] and w[0] <= dat_i; no shift when val_i=0.
REQ-012 Fill counter: 0..WIN-1; increments on each accepted sample while below WIN-1, then saturates.
REQ-013 Sample is "full" when the fill counter equals WIN-1 at acceptance, i.e. the window holds WIN real samples after the shift; first full sample = WIN-th sample after reset/clear.
REQ-014 Stage 1 (edge A, acceptance): window shift; v1 <= val_i AND (full OR mode_i==3); m1 <= mode_i; byp1 <= dat_i.
REQ-015 Stage 2 (edge A+1): rank r[i] per slot = count of j!=i with w[j]<w[i], or w[j]==w[i] and j<i; ranks form a permutation of 0..WIN-1; registered together with window copy, v2 <= v1, m2 <= m1, byp2 <= byp1.
REQ-016 Stage 3 (edge A+2): dat_o <= slot with rank (WIN-1)/2 (mode 0), rank 0 (mode 1), rank WIN-1 (mode 2), byp2 (mode 3); val_o <= v2.
REQ-017 Latency: val_o/dat_o valid exactly 2 cycles after the accepting edge; throughput one result per clock with val_i held high.
REQ-018 Mode is captured with the sample (m1); a mode change applies to the sample accepted in the same cycle, never to samples already in flight.
REQ-019 Bypass (mode 3) outputs every accepted sample, including during fill; the window still shifts and the fill counter still counts.
REQ-020 Between results val_o=0 and dat_o holds its last value.
REQ-021 clr_i=1: fill counter <= 0, window <= 0, v1 and v2 <= 0 (in-flight results discarded); val_o on the following edge is 0.
REQ-022 clr_i and val_i both high: clear takes priority, then dat_i is accepted as sample 1 of the new window (w[0]=dat_i, fill=1, v1 = (mode_i==3)).
REQ-023 Ranks use unsigned compares at full DATA_W; rank counters are clog2(WIN) bits wide; no arithmetic on sample values.

Reset
REQ-024 rst_n=0 asynchronously forces window, fill counter, v1, v2, m1, m2, byp1, byp2, rank registers, dat_o and val_o to 0.
REQ-025 Release of rst_n is synchronised externally; first acceptance is allowed on the first rising edge with rst_n=1.
REQ-026 Reset mid-operation discards the window and all in-flight results; the next output after reset requires WIN new samples (modes 0-2).

Verification (DATA_W=8, WIN=5)
REQ-027 Mode 0, val_i high, 10,50,30,20,40,60 -> val_o=0 for first 4 samples; then dat_o=30 two cycles after sample 5, dat_o=40 one cycle later.
REQ-028 Ties: 7,7,7,3,9 in modes 0/1/2 (fresh window each) -> 7 / 3 / 9; mode 3 with 1,2,3 -> 1,2,3 with val_o from the first sample, latency 2.
REQ-029 Gapped input: 10,_,50,_,_,30,20,_,40 (_ = val_i=0) -> exactly one val_o pulse, dat_o=30, 2 cycles after the 40 is accepted; dat_o unchanged elsewhere.
REQ-030 Mode switched 0->2 on sample 6 of 10,50,30,20,40,60 -> outputs 30 then 60; switch-back on sample 7 (value 5) -> 30.
REQ-031 clr_i pulsed with val_i on sample 6 of a full stream -> no output for that or the next 3 samples, in-flight result for sample 5 suppressed, output resumes at new sample 5.
REQ-032 rst_n dropped asynchronously mid-stream -> all outputs 0 immediately; after release, 4 samples give no val_o, 5th gives median of the post-reset samples only.

Source files
------------

// File: rtl/median_filter_par.sv
// Three-stage windowed rank filter: median, min, max or bypass
// of a WIN-deep sliding window of unsigned samples.
module median_filter_par #(
    parameter int DATA_W = 8,
    parameter int WIN    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              val_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              val_o
);

    localparam int RW = $clog2(WIN);
    localparam logic [RW-1:0] FILL_MAX = RW'(WIN - 1);
    localparam logic [RW-1:0] MID      = RW'((WIN - 1) / 2);

    if (WIN < 3 || WIN > 9 || (WIN % 2) == 0) begin : g_win_chk
        $error("median_filter_par: WIN must be odd in 3..9");
    end
    if (DATA_W < 2 || DATA_W > 16) begin : g_dw_chk
        $error("median_filter_par: DATA_W must be in 2..16");
    end

    logic [DATA_W-1:0] w_q    [WIN];
    logic [DATA_W-1:0] w_d    [WIN];
    logic [RW-1:0]     fill_q, fill_d;
    logic              v1_q, v1_d;
    logic [1:0]        m1_q, m1_d;
    logic [DATA_W-1:0] byp1_q, byp1_d;
    logic              full;

    logic [DATA_W-1:0] wc_q   [WIN];
    logic [DATA_W-1:0] wc_d   [WIN];
    logic [RW-1:0]     r_q    [WIN];
    logic [RW-1:0]     r_d    [WIN];
    logic              v2_q, v2_d;
    logic [1:0]        m2_q, m2_d;
    logic [DATA_W-1:0] byp2_q, byp2_d;

    logic [DATA_W-1:0] dat_q, dat_d;
    logic              val_q, val_d;
    logic [RW-1:0]     tgt;
    logic [DATA_W-1:0] pick;

    // Stage 1: flush, shift and fill tracking; clear wins over the old window
    always_comb begin
        full   = 1'b0;
        fill_d = fill_q;
        for (int k = 0; k < WIN; k++) begin
            w_d[k] = clr_i ? '0 : w_q[k];
        end
        if (clr_i) begin
            fill_d = '0;
        end
        if (val_i) begin
            full = !clr_i && (fill_q == FILL_MAX);
            for (int k = WIN - 1; k > 0; k--) begin
                w_d[k] = clr_i ? '0 : w_q[k-1];
            end
            w_d[0] = dat_i;
            if (clr_i) begin
                fill_d = RW'(1);
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + RW'(1);
            end
        end
        v1_d   = val_i && (full || mode_i == 2'd3);
        m1_d   = mode_i;
        byp1_d = dat_i;
    end

    // Stage 2: equal values are ordered by slot index, so ranks stay unique
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            r_d[i]  = '0;
            wc_d[i] = w_q[i];
            for (int j = 0; j < WIN; j++) begin
                if (j != i) begin
                    if (w_q[j] < w_q[i] || (w_q[j] == w_q[i] && j < i)) begin
                        r_d[i] = r_d[i] + RW'(1);
                    end
                end
            end
        end
        v2_d   = clr_i ? 1'b0 : v1_q;
        m2_d   = m1_q;
        byp2_d = byp1_q;
    end

    always_comb begin
        tgt  = '0;
        pick = '0;
        unique case (m2_q)
            2'd0:    tgt = MID;
            2'd2:    tgt = FILL_MAX;
            default: tgt = '0;
        endcase
        for (int i = 0; i < WIN; i++) begin
            if (r_q[i] == tgt) begin
                pick = wc_q[i];
            end
        end
        val_d = v2_q;
        dat_d = dat_q;
        if (v2_q) begin
            dat_d = (m2_q == 2'd3) ? byp2_q : pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIN; k++) begin
                w_q[k]  <= '0;
                wc_q[k] <= '0;
                r_q[k]  <= '0;
            end
            fill_q <= '0;
            v1_q   <= 1'b0;
            m1_q   <= '0;
            byp1_q <= '0;
            v2_q   <= 1'b0;
            m2_q   <= '0;
            byp2_q <= '0;
            dat_q  <= '0;
            val_q  <= 1'b0;
        end else begin
            for (int k = 0; k < WIN; k++) begin
                w_q[k]  <= w_d[k];
                wc_q[k] <= wc_d[k];
                r_q[k]  <= r_d[k];
            end
            fill_q <= fill_d;
            v1_q   <= v1_d;
            m1_q   <= m1_d;
            byp1_q <= byp1_d;
            v2_q   <= v2_d;
            m2_q   <= m2_d;
            byp2_q <= byp2_d;
            dat_q  <= dat_d;
            val_q  <= val_d;
        end
    end

    assign dat_o = dat_q;
    assign val_o = val_q;

endmodule

// File: tb/tb_median_filter_par.sv
// Directed bench for median_filter_par with a sorted-window
// reference model checked every cycle.
module tb_median_filter_par;

    localparam int DW = 8;
    localparam int WN = 5;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          clr_i  = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic [DW-1:0] dat_i  = '0;
    logic          val_i  = 1'b0;
    logic [DW-1:0] dat_o;
    logic          val_o;

    median_filter_par #(.DATA_W(DW), .WIN(WN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_i),
        .mode_i (mode_i),
        .dat_i  (dat_i),
        .val_i  (val_i),
        .dat_o  (dat_o),
        .val_o  (val_o)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  chk_en = 1'b0;
    bit  expv [4096];
    int  expd [4096];
    int  lastd = 0;
    int  win [$];
    int  got_d [$];
    int  got_c [$];
    int  acc;

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Reference: window as a queue of real samples, results by sorting
    function automatic void model(bit v, int d, int m, bit c);
        bit full;
        int res;
        int s [$];
        full = 1'b0;
        res  = 0;
        if (c) begin
            win.delete();
            expv[cyc+1] = 1'b0;
        end
        if (v) begin
            win.push_front(d);
            if (win.size() > WN) void'(win.pop_back());
            full = (win.size() == WN);
            if (m == 3) begin
                res = d;
            end else if (full) begin
                s = win;
                s.sort();
                res = (m == 0) ? s[WN/2] : (m == 1) ? s[0] : s[WN-1];
            end
            if (m == 3 || full) begin
                expv[cyc+2] = 1'b1;
                expd[cyc+2] = res;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (expv[cyc]) lastd = expd[cyc];
            checks++;
            if (val_o !== expv[cyc]) begin
                errors++;
                $display("FAIL val_o cyc %0d got %0b want %0b",
                         cyc, val_o, expv[cyc]);
            end
            checks++;
            if (int'(dat_o) !== lastd) begin
                errors++;
                $display("FAIL dat_o cyc %0d got %0d want %0d",
                         cyc, dat_o, lastd);
            end
            if (val_o) begin
                got_d.push_back(int'(dat_o));
                got_c.push_back(cyc);
            end
        end
    end

    task automatic step(bit v, int d, int m, bit c);
        @(negedge clk);
        val_i  = v;
        dat_i  = DW'(d);
        mode_i = 2'(m);
        clr_i  = c;
        @(posedge clk);
        cyc++;
        model(v, d, m, c);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        val_i = 1'b0;
        clr_i = 1'b0;
        #1;
        chk("rst_dat", int'(dat_o), 0);
        chk("rst_val", int'(val_o), 0);
        win.delete();
        expv[cyc+1] = 1'b0;
        expv[cyc+2] = 1'b0;
        lastd = 0;
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    task automatic reset_got();
        got_d.delete();
        got_c.delete();
    endtask

    initial begin
        int s27 [6];
        int tie [5];
        int twant [3];
        int gap [9];
        s27   = '{10, 50, 30, 20, 40, 60};
        tie   = '{7, 7, 7, 3, 9};
        twant = '{7, 3, 9};
        gap   = '{10, -1, 50, -1, -1, 30, 20, -1, 40};

        do_reset(2);
        chk_en = 1'b1;

        // median stream, latency and throughput
        reset_got();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, s27[i], 0, 1'b0);
            if (i == 4) acc = cyc;
        end
        idle(3);
        chk("med_n", got_d.size(), 2);
        chk("med_0", got_d[0], 30);
        chk("med_1", got_d[1], 40);
        chk("med_lat", got_c[0], acc + 2);
        chk("med_tput", got_c[1], acc + 3);

        // ties in median/min/max
        for (int m = 0; m < 3; m++) begin
            step(1'b0, 0, 0, 1'b1);
            reset_got();
            for (int i = 0; i < 5; i++) step(1'b1, tie[i], m, 1'b0);
            idle(3);
            chk("tie_n", got_d.size(), 1);
            chk("tie_v", got_d[0], twant[m]);
        end

        // bypass during fill
        step(1'b0, 0, 0, 1'b1);
        reset_got();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, i, 3, 1'b0);
            if (i == 1) acc = cyc;
        end
        idle(3);
        chk("byp_n", got_d.size(), 3);
        chk("byp_0", got_d[0], 1);
        chk("byp_2", got_d[2], 3);
        chk("byp_lat", got_c[0], acc + 2);

        // gapped input
        step(1'b0, 0, 0, 1'b1);
        reset_got();
        for (int i = 0; i < 9; i++) begin
            if (gap[i] < 0) step(1'b0, 0, 0, 1'b0);
            else step(1'b1, gap[i], 0, 1'b0);
        end
        acc = cyc;
        idle(3);
        chk("gap_n", got_d.size(), 1);
        chk("gap_v", got_d[0], 30);
        chk("gap_lat", got_c[0], acc + 2);

        // mode captured with the sample
        step(1'b0, 0, 0, 1'b1);
        reset_got();
        for (int i = 0; i < 5; i++) step(1'b1, s27[i], 0, 1'b0);
        step(1'b1, 60, 2, 1'b0);
        step(1'b1, 5, 0, 1'b0);
        idle(3);
        chk("mode_n", got_d.size(), 3);
        chk("mode_0", got_d[0], 30);
        chk("mode_1", got_d[1], 60);
        chk("mode_2", got_d[2], 30);

        // clear with a sample mid-stream
        step(1'b0, 0, 0, 1'b1);
        idle(2);
        reset_got();
        for (int i = 1; i <= 5; i++) step(1'b1, 10 * i, 0, 1'b0);
        step(1'b1, 60, 0, 1'b1);
        for (int i = 7; i <= 10; i++) step(1'b1, 10 * i, 0, 1'b0);
        acc = cyc;
        idle(3);
        chk("clr_n", got_d.size(), 1);
        chk("clr_v", got_d[0], 80);
        chk("clr_lat", got_c[0], acc + 2);

        // async reset mid-stream
        for (int i = 0; i < 7; i++) step(1'b1, 20 + i, 0, 1'b0);
        do_reset(2);
        reset_got();
        step(1'b1, 9, 0, 1'b0);
        step(1'b1, 1, 0, 1'b0);
        step(1'b1, 5, 0, 1'b0);
        step(1'b1, 3, 0, 1'b0);
        step(1'b1, 7, 0, 1'b0);
        acc = cyc;
        idle(3);
        chk("rst_n_cnt", got_d.size(), 1);
        chk("rst_med", got_d[0], 5);
        chk("rst_lat", got_c[0], acc + 2);

        // mixed modes, gaps and clears against the model only
        for (int i = 0; i < 60; i++) begin
            step(i % 7 != 3, (i * 37 + 11) % 256, (i / 9) % 4, i % 13 == 6);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
